cla_pipe_adder: RTL

Parametrised, pipelined carry-lookahead adder: the operand word is split into 4-bit lookahead groups, one group resolved per pipeline stage, with the group carry registered between stages. A valid/ready handshake on both sides allows back-to-back streaming and output back-pressure. It sits in the arithmetic datapath wherever a wide add must close timing at full clock rate. Sum, carry-out and signed-overflow flags are produced.

---
 rtl/cla_pipe_adder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
`default_nettype none
//==============================================================================
// Module   : cla_pipe_adder
// Brief    : Pipelined carry-lookahead adder, one 4-bit group per stage, with
//            valid/ready on both sides. Define CLA_SUB_EN for subtract mode.
// Revision : 1.0 - initial release
//==============================================================================
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int NS = WIDTH / GROUP;

   // Returns {c4, sum[3:0]}; every carry is a flat sum of products.
   function automatic logic [4:0] cla4(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       ci
   );
      logic [3:0] g;
      logic [3:0] p;
      logic       c1;
      logic       c2;
      logic       c3;
      logic       c4;
      g  = a & b;
      p  = a ^ b;
      c1 = g[0] | (p[0] & ci);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c4, p ^ {c3, c2, c1, ci}};
   endfunction

   logic w_en;
   logic r_ovf;

   assign w_en     = ~out_valid | out_ready;
   assign in_ready = w_en;

   // Unresolved operand bits still to be consumed by later stages.
   for (genvar s = 0; s < NS - 1; s++) begin : g_opnd
      localparam int c_rw = WIDTH - GROUP * (s + 1);
      logic [c_rw-1:0] r_a;
      logic [c_rw-1:0] r_b;
`ifdef CLA_SUB_EN
      logic            r_sub;
`endif
      if (s == 0) begin : g_load
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a   <= '0;
               r_b   <= '0;
`ifdef CLA_SUB_EN
               r_sub <= 1'b0;
`endif
            end else if (w_en) begin
               r_a   <= A[WIDTH-1:GROUP];
               r_b   <= B[WIDTH-1:GROUP];
`ifdef CLA_SUB_EN
               r_sub <= sub;
`endif
            end
         end
      end else begin : g_shift
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a   <= '0;
               r_b   <= '0;
`ifdef CLA_SUB_EN
               r_sub <= 1'b0;
`endif
            end else if (w_en) begin
               r_a   <= g_opnd[s-1].r_a[c_rw+GROUP-1:GROUP];
               r_b   <= g_opnd[s-1].r_b[c_rw+GROUP-1:GROUP];
`ifdef CLA_SUB_EN
               r_sub <= g_opnd[s-1].r_sub;
`endif
            end
         end
      end
   end

   for (genvar s = 0; s < NS; s++) begin : g_stage
      logic [GROUP-1:0]         w_a;
      logic [GROUP-1:0]         w_b;
      logic                     w_ci;
      logic                     w_vin;
      logic [4:0]               w_res;
      logic [GROUP*(s+1)-1:0]   w_sum_nxt;
      logic                     r_v;
      logic                     r_c;
      logic [GROUP*(s+1)-1:0]   r_sum;

      if (s == 0) begin : g_first
         assign w_a = A[GROUP-1:0];
`ifdef CLA_SUB_EN
         // Subtract as A + ~B + 1; the forced carry-in replaces Cin.
         assign w_b  = B[GROUP-1:0] ^ {GROUP{sub}};
         assign w_ci = sub | Cin;
`else
         assign w_b  = B[GROUP-1:0];
         assign w_ci = Cin;
`endif
         assign w_vin     = in_valid;
         assign w_sum_nxt = w_res[3:0];
      end else begin : g_rest
         assign w_a = g_opnd[s-1].r_a[GROUP-1:0];
`ifdef CLA_SUB_EN
         assign w_b = g_opnd[s-1].r_b[GROUP-1:0] ^ {GROUP{g_opnd[s-1].r_sub}};
`else
         assign w_b = g_opnd[s-1].r_b[GROUP-1:0];
`endif
         assign w_ci      = g_stage[s-1].r_c;
         assign w_vin     = g_stage[s-1].r_v;
         assign w_sum_nxt = {w_res[3:0], g_stage[s-1].r_sum};
      end

      assign w_res = cla4(w_a, w_b, w_ci);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_sum <= '0;
         end else if (w_en) begin
            r_v   <= w_vin;
            r_c   <= w_res[4];
            r_sum <= w_sum_nxt;
         end
      end
   end

   // Carry into the MSB recovered as sum ^ a ^ b of the top bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_en) begin
         r_ovf <= g_stage[NS-1].w_res[4] ^ (g_stage[NS-1].w_res[3]
                ^ g_stage[NS-1].w_a[GROUP-1] ^ g_stage[NS-1].w_b[GROUP-1]);
      end
   end

   assign out_valid = g_stage[NS-1].r_v;
   assign Sum       = g_stage[NS-1].r_sum;
   assign Cout      = g_stage[NS-1].r_c;
   assign Ovf       = r_ovf;

endmodule
`default_nettype wire
